fifo_sync: RTL and testbench
============================

// Module: fifo_sync
// PURPOSE
//  Single-clock, parametrised FIFO with a true occupancy count and runtime-programmable
//  almost-full/almost-empty thresholds. Flags overflow/underflow as sticky errors.
//  Has a synchronous flush. Used for rate buffering inside one clock domain, where the
//  dual-clock FIFO's gray-code synchronisers are unnecessary latency.
// PARAMETERS
//  DW    104             data width (>=1)
//  DEPTH 32              entries; power of two, >=2
//  AW    $clog2(DEPTH)   address width; count/level ports are AW+1 bits wide
// PORTS
//  clk             in   1     clock; all logic on posedge
//  nreset          in   1     asynchronous active-low reset
//  clear           in   1     synchronous flush, priority over wr_en/rd_en
//  wr_en           in   1     write request
//  din             in   DW    write data
//  rd_en           in   1     read (pop) request
//  dout            out  DW    read data
//  empty           out  1     no readable word
//  full            out  1     count==DEPTH
//  prog_full       out  1     count >= prog_full_lvl
//  prog_empty      out  1     count <= prog_empty_lvl
//  prog_full_lvl   in   AW+1  almost-full threshold (1..DEPTH; >DEPTH => never asserts)
//  prog_empty_lvl  in   AW+1  almost-empty threshold
//  count           out  AW+1  words held (0..DEPTH)
//  overflow        out  1     sticky: write attempted while full
//  underflow       out  1     sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (async, nreset low): wr_ptr=rd_ptr=count=0, empty=1, full=0, dout=0,
//    overflow=underflow=0. prog_full=0 for legal lvl; prog_empty=1.
//  - Pointers are AW+1 bits; the MSB tracks wrap. Storage is a DEPTH x DW register array
//    indexed by ptr[AW-1:0]. Pointers wrap naturally modulo 2*DEPTH.
//  - count, empty and full are registered and updated together each edge:
//    count_next = count + wr_ok - rd_ok.
//  - wr_ok = wr_en & ~full. If wr_en & full: data is dropped and overflow is set next edge.
//  - rd_ok = rd_en & ~empty. If rd_en & empty: no pointer change, underflow set next edge.
//  - Acceptance uses flags from the start of the cycle. Both requests in the same cycle:
//    - when full: read accepted, write dropped (overflow set).
//    - when empty: write accepted, read refused (underflow set).
//    - otherwise: both accepted, count unchanged.
//  - Standard read: on rd_ok, dout loads mem[rd_ptr] at that edge (1-cycle latency).
//    dout holds its value at all other times, including when empty.
//  - prog_full and prog_empty are combinational compares of the registered count against
//    the level inputs. Level changes take effect the same cycle.
//  - clear=1: ptrs, count, overflow and underflow go to 0, empty=1, at the next edge.
//    wr_en/rd_en are ignored that cycle. dout holds.
//  - Reset mid-operation discards all contents immediately.
// CONFIGURATION
//  FIFO_SYNC_FWFT_EN defined: first-word fall-through mode.
//    - A DW output register holds the head word; dout is valid whenever empty=0.
//    - rd_en & ~empty pops the head and refills it from the array in the same edge.
//      If the array is empty, bypass: a concurrent write goes straight to the register.
//    - Write into an empty FIFO: empty deasserts 1 cycle after the write edge.
//    - count includes the word in the output register; full still means count==DEPTH.
//    - clear invalidates the output register (empty=1); dout value holds.
//  Not defined: standard mode as described above; no output-stage register.
// TESTING
//  1 Reset, then write 0x1..0x20 (DEPTH=32) -> full=1 and count=32 after the 32nd edge;
//    33rd write is dropped and overflow=1.
//  2 Read 32 words -> dout sequence 0x1..0x20, empty=1 after last; an extra rd_en sets
//    underflow=1 and dout stays 0x20.
//  3 prog_full_lvl=24, prog_empty_lvl=4 -> prog_full rises on the edge count reaches 24;
//    prog_empty=1 for count<=4 only.
//  4 At count=16, wr_en=rd_en=1 for 100 cycles with incrementing data -> count stays 16,
//    no flag errors, data in order (exercises pointer wrap).
//  5 With count=10 and overflow set, pulse clear together with wr_en -> count=0, empty=1,
//    overflow=0, write ignored.
//  6 FWFT build: single write 0xAB into empty -> empty=0 and dout=0xAB one cycle after the
//    write edge, before any rd_en; rd_en -> empty=1.

Source files
------------

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty levels,
// sticky overflow/underflow and synchronous flush. Define FIFO_SYNC_FWFT_EN for fall-through.
module fifo_sync #(
  parameter int unsigned DW    = 104,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic          prog_full,
  output logic          prog_empty,
  input  logic [AW:0]   prog_full_lvl,
  input  logic [AW:0]   prog_empty_lvl,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] DepthCnt = DEPTH[AW:0];
  localparam logic [AW:0] One      = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic          empty_q, empty_d, full_q, full_d;
  logic          overflow_q, overflow_d, underflow_q, underflow_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          wr_ok, rd_ok, mem_we;
`ifdef FIFO_SYNC_FWFT_EN
  logic          head_valid_q, head_valid_d;
  logic          arr_empty, bypass;
`endif

  always_comb begin
    wr_ok       = wr_en & ~full_q;
    rd_ok       = rd_en & ~empty_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    dout_d      = dout_q;
    mem_we      = 1'b0;
    overflow_d  = overflow_q | (wr_en & full_q);
    underflow_d = underflow_q | (rd_en & empty_q);
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + One;
      2'b01:   count_d = count_q - One;
      default: count_d = count_q;
    endcase
`ifdef FIFO_SYNC_FWFT_EN
    arr_empty    = (wr_ptr_q == rd_ptr_q);
    bypass       = 1'b0;
    head_valid_d = head_valid_q;
    // Head register refills whenever it is vacant or being popped.
    if (!head_valid_q || rd_ok) begin
      if (!arr_empty) begin
        dout_d       = mem_q[rd_ptr_q[AW-1:0]];
        rd_ptr_d     = rd_ptr_q + One;
        head_valid_d = 1'b1;
      end else if (wr_ok && head_valid_q) begin
        bypass       = 1'b1;
        dout_d       = din;
        head_valid_d = 1'b1;
      end else begin
        head_valid_d = 1'b0;
      end
    end
    if (wr_ok && !bypass) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + One;
    end
    empty_d = ~head_valid_d;
`else
    if (rd_ok) begin
      dout_d   = mem_q[rd_ptr_q[AW-1:0]];
      rd_ptr_d = rd_ptr_q + One;
    end
    if (wr_ok) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + One;
    end
    empty_d = (count_d == '0);
`endif
    full_d = (count_d == DepthCnt);
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      empty_d     = 1'b1;
      full_d      = 1'b0;
      mem_we      = 1'b0;
      dout_d      = dout_q;
`ifdef FIFO_SYNC_FWFT_EN
      head_valid_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      dout_q      <= '0;
`ifdef FIFO_SYNC_FWFT_EN
      head_valid_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      dout_q      <= dout_d;
`ifdef FIFO_SYNC_FWFT_EN
      head_valid_q <= head_valid_d;
`endif
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  always_comb begin
    dout       = dout_q;
    empty      = empty_q;
    full       = full_q;
    count      = count_q;
    overflow   = overflow_q;
    underflow  = underflow_q;
    prog_full  = (count_q >= prog_full_lvl);
    prog_empty = (count_q <= prog_empty_lvl);
  end

endmodule

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync (DW=104, DEPTH=32).
module tb_fifo_sync;
  localparam int DW    = 104;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk, nreset, clear, wr_en, rd_en;
  logic [DW-1:0] din, dout;
  logic          empty, full, prog_full, prog_empty, overflow, underflow;
  logic [AW:0]   prog_full_lvl, prog_empty_lvl, count;

  int checks = 0;
  int errors = 0;
  int wv, rv;

  fifo_sync #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .nreset(nreset), .clear(clear), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .empty(empty), .full(full), .prog_full(prog_full), .prog_empty(prog_empty),
    .prog_full_lvl(prog_full_lvl), .prog_empty_lvl(prog_empty_lvl), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    nreset = 1'b0; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    prog_full_lvl = 6'd24; prog_empty_lvl = 6'd4;
    #12;
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %0h want 0", dout); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_sticky: got %b want 00", {overflow, underflow}); end
    checks++; if ({prog_full, prog_empty} !== 2'b01) begin errors++; $display("FAIL reset_prog: got %b want 01", {prog_full, prog_empty}); end
    nreset = 1'b1;
  endtask

`ifndef FIFO_SYNC_FWFT_EN
  task automatic test_fill;
    for (int i = 1; i <= DEPTH; i++) begin
      wr_en = 1'b1; din = DW'(i);
      tick();
      checks++; if (count !== 6'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i); end
      checks++; if (prog_full !== (i >= 24)) begin errors++; $display("FAIL fill_prog_full[%0d]: got %b want %b", i, prog_full, i >= 24); end
      checks++; if (prog_empty !== (i <= 4)) begin errors++; $display("FAIL fill_prog_empty[%0d]: got %b want %b", i, prog_empty, i <= 4); end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf: got %b want 0", overflow); end
    din = DW'(33);
    tick();
    wr_en = 1'b0;
    checks++; if (count !== 6'd32) begin errors++; $display("FAIL ovf_count: got %0d want 32", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    prog_full_lvl = 6'd33;
    #1;
    checks++; if (prog_full !== 1'b0) begin errors++; $display("FAIL prog_full_lvl33: got %b want 0", prog_full); end
    prog_full_lvl = 6'd24;
    #1;
    checks++; if (prog_full !== 1'b1) begin errors++; $display("FAIL prog_full_lvl24: got %b want 1", prog_full); end
  endtask

  task automatic test_drain;
    for (int i = 1; i <= DEPTH; i++) begin
      rd_en = 1'b1;
      tick();
      checks++; if (dout !== DW'(i)) begin errors++; $display("FAIL drain_dout[%0d]: got %0h want %0h", i, dout, i); end
      checks++; if (count !== 6'(DEPTH - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, DEPTH - i); end
      checks++; if (prog_empty !== (DEPTH - i <= 4)) begin errors++; $display("FAIL drain_prog_empty[%0d]: got %b", i, prog_empty); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", empty); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL drain_no_udf: got %b want 0", underflow); end
    tick();
    rd_en = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_flag: got %b want 1", underflow); end
    checks++; if (dout !== DW'(32)) begin errors++; $display("FAIL udf_dout: got %0h want 20", dout); end
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL udf_count: got %0d want 0", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL clear_sticky: got %b want 00", {overflow, underflow}); end
  endtask

  task automatic test_back_to_back;
    wv = 'h100; rv = 'h100;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; din = DW'(wv); wv++;
      tick();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      din = DW'(wv); wv++;
      tick();
      checks++; if (dout !== DW'(rv)) begin errors++; $display("FAIL b2b_dout[%0d]: got %0h want %0h", i, dout, rv); end
      checks++; if (count !== 6'd16) begin errors++; $display("FAIL b2b_count[%0d]: got %0d want 16", i, count); end
      rv++;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL b2b_sticky: got %b want 00", {overflow, underflow}); end
  endtask

  task automatic test_clear;
    logic [DW-1:0] last;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; din = DW'(wv); wv++;
      tick();
    end
    din = DW'('hdead);
    tick();
    wr_en = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_pre_ovf: got %b want 1", overflow); end
    rd_en = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick();
      checks++; if (dout !== DW'(rv)) begin errors++; $display("FAIL clr_pre_dout[%0d]: got %0h want %0h", i, dout, rv); end
      rv++;
    end
    rd_en = 1'b0;
    last = DW'(rv - 1);
    checks++; if (count !== 6'd10) begin errors++; $display("FAIL clr_pre_count: got %0d want 10", count); end
    clear = 1'b1; wr_en = 1'b1; din = DW'('hbeef);
    tick();
    clear = 1'b0; wr_en = 1'b0;
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL clr_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL clr_empty: got %b want 1", empty); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b want 0", overflow); end
    checks++; if (dout !== last) begin errors++; $display("FAIL clr_dout_hold: got %0h want %0h", dout, last); end
    tick();
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL clr_write_ignored: got %0d want 0", count); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; din = DW'(i + 7);
      tick();
    end
    wr_en = 1'b0;
    checks++; if (count !== 6'd3) begin errors++; $display("FAIL arst_pre_count: got %0d want 3", count); end
    #2 nreset = 1'b0;
    #1;
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL arst_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst_empty: got %b want 1", empty); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL arst_dout: got %0h want 0", dout); end
    nreset = 1'b1;
  endtask
`else
  task automatic test_fwft;
    wr_en = 1'b1; din = DW'('hAB);
    tick();
    wr_en = 1'b0;
    checks++; if (count !== 6'd1) begin errors++; $display("FAIL fwft_count: got %0d want 1", count); end
    tick();
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fwft_empty: got %b want 0", empty); end
    checks++; if (dout !== DW'('hAB)) begin errors++; $display("FAIL fwft_dout: got %0h want ab", dout); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fwft_pop_empty: got %b want 1", empty); end
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL fwft_pop_count: got %0d want 0", count); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef FIFO_SYNC_FWFT_EN
    test_fill();
    test_drain();
    test_back_to_back();
    test_clear();
    test_async_reset();
`else
    test_fwft();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
